// File: rtl/ensemble_pkg.sv
// Shared constants and types for the ensemble vote collector: agreement
// encodings, output field placement and the collector state enum.
package ensemble_pkg;

  localparam int DEF_CLASS_WIDTH = 8;

  localparam logic [1:0] AGREE_ALL = 2'd3;
  localparam logic [1:0] AGREE_MAJ = 2'd2;
  localparam logic [1:0] AGREE_TIE = 2'd1;

  localparam int AGREE_LSB = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

endpackage

// File: rtl/ensemble_vote_collector_vote.sv
// majority_vote3: purely combinational 3-way majority vote with a fixed
// tie-break slot and an agreement count.
module majority_vote3
  import ensemble_pkg::*;
#(
  parameter int W       = DEF_CLASS_WIDTH,
  parameter int TIE_SEL = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] winner,
  output logic [1:0]   agree
);

  logic ab, ac, bc;

  assign ab = (a == b);
  assign ac = (a == c);
  assign bc = (b == c);

  // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    winner = a;
    agree  = AGREE_TIE;
    if (ab && ac) begin
      agree = AGREE_ALL;
    end else if (ab || ac) begin
      agree = AGREE_MAJ;
    end else if (bc) begin
      winner = b;
      agree  = AGREE_MAJ;
    end else if (TIE_SEL == 0) begin
      winner = a;
    end else if (TIE_SEL == 1) begin
      winner = b;
    end else begin
      winner = c;
    end
  end

endmodule

// File: rtl/ensemble_vote_collector.sv
// Collects one class result from each of three AXI-Stream classifiers, votes,
// and emits a single-beat fused result. Optional stats: ENSEMBLE_VOTE_STATS_EN.
module ensemble_vote_collector
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = DEF_CLASS_WIDTH,
  parameter int TIE_SEL     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
  input  logic                  s_axis_tvalid_3,
  output logic                  s_axis_tready_3,
  input  logic                  s_axis_tlast_3,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
`ifdef ENSEMBLE_VOTE_STATS_EN
  ,
  output logic [31:0]           disagree_cnt,
  output logic                  tlast_err
`endif
);

  state_t                 state, state_next;
  logic                   run;
  logic [2:0]             in_valid, in_last, in_ready, accept, full;
  logic [CLASS_WIDTH-1:0] in_class [3];
  logic [CLASS_WIDTH-1:0] slot     [3];
  logic [CLASS_WIDTH-1:0] winner;
  logic [1:0]             agree;
  logic [DATA_WIDTH-1:0]  vote_word;
  logic                   vote_ready, out_hs;
  logic                   unused_inputs;

  assign in_valid    = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1};
  assign in_last     = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1};
  assign in_class[0] = s_axis_tdata_1[CLASS_WIDTH-1:0];
  assign in_class[1] = s_axis_tdata_2[CLASS_WIDTH-1:0];
  assign in_class[2] = s_axis_tdata_3[CLASS_WIDTH-1:0];

  // Class bits above CLASS_WIDTH and tkeep carry no information for the vote.
  assign unused_inputs = ^{s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3, in_last,
                           s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_3[DATA_WIDTH-1:CLASS_WIDTH]};

  assign in_ready        = {3{run & (state == COLLECT)}} & ~full;
  assign accept          = in_valid & in_ready;
  assign s_axis_tready_1 = in_ready[0];
  assign s_axis_tready_2 = in_ready[1];
  assign s_axis_tready_3 = in_ready[2];

  assign vote_ready = (state == COLLECT) & (&full);
  assign out_hs     = m_axis_tvalid & m_axis_tready;

  // Holds readies low until the first edge after reset release.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (&full)  state_next = OUTPUT;
      OUTPUT:  if (out_hs) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      full <= '0;
    else if (out_hs) full <= '0;
    else             full <= full | accept;
  end

  // NOTE: slot contents are qualified by the full flags, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (accept[i]) slot[i] <= in_class[i];
    end
  end

  majority_vote3 #(
    .W       (CLASS_WIDTH),
    .TIE_SEL (TIE_SEL)
  ) u_vote (
    .a      (slot[0]),
    .b      (slot[1]),
    .c      (slot[2]),
    .winner (winner),
    .agree  (agree)
  );

  always_comb begin
    vote_word                    = '0;
    vote_word[CLASS_WIDTH-1:0]   = winner;
    vote_word[AGREE_LSB +: 2]    = agree;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (vote_ready) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= vote_word;
      m_axis_tkeep  <= '1;
      m_axis_tlast  <= 1'b1;
    end else if (out_hs) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end
  end

`ifdef ENSEMBLE_VOTE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disagree_cnt <= '0;
      tlast_err    <= 1'b0;
    end else begin
      if (out_hs && (m_axis_tdata[AGREE_LSB +: 2] != AGREE_ALL) && (disagree_cnt != '1))
        disagree_cnt <= disagree_cnt + 32'd1;
      if (|(accept & ~in_last))
        tlast_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ensemble_vote_collector.sv
// Self-checking bench for ensemble_vote_collector: two DUTs (tie slot 2 and 0)
// share stimulus; a count-based vote model is compared every cycle.
module tb_ensemble_vote_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  tv = '0;
  logic [2:0]  tl = 3'b111;
  logic [31:0] td [3];
  logic        m_tready = 1'b1;

  logic [2:0]  rdy, rdy0;
  logic [31:0] m_tdata, m_tdata0;
  logic [3:0]  m_tkeep, m_tkeep0;
  logic        m_tvalid, m_tvalid0, m_tlast, m_tlast0;
`ifdef ENSEMBLE_VOTE_STATS_EN
  logic [31:0] dis_cnt, dis_cnt0;
  logic        terr, terr0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Model state
  bit          m_run;
  bit [2:0]    have;
  int          cls [3];
  bit          o_valid;
  logic [31:0] o_data2, o_data0;
  int          n_out = 0;
  logic [31:0] last_out, last_out0;
`ifdef ENSEMBLE_VOTE_STATS_EN
  int          dis_m;
  bit          terr_m;
`endif

  always #5 clk = ~clk;

  ensemble_vote_collector #(.TIE_SEL(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata_1(td[0]), .s_axis_tkeep_1(4'hF), .s_axis_tvalid_1(tv[0]),
    .s_axis_tready_1(rdy[0]), .s_axis_tlast_1(tl[0]),
    .s_axis_tdata_2(td[1]), .s_axis_tkeep_2(4'hF), .s_axis_tvalid_2(tv[1]),
    .s_axis_tready_2(rdy[1]), .s_axis_tlast_2(tl[1]),
    .s_axis_tdata_3(td[2]), .s_axis_tkeep_3(4'hF), .s_axis_tvalid_3(tv[2]),
    .s_axis_tready_3(rdy[2]), .s_axis_tlast_3(tl[2]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
`ifdef ENSEMBLE_VOTE_STATS_EN
    , .disagree_cnt(dis_cnt), .tlast_err(terr)
`endif
  );

  ensemble_vote_collector #(.TIE_SEL(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata_1(td[0]), .s_axis_tkeep_1(4'hF), .s_axis_tvalid_1(tv[0]),
    .s_axis_tready_1(rdy0[0]), .s_axis_tlast_1(tl[0]),
    .s_axis_tdata_2(td[1]), .s_axis_tkeep_2(4'hF), .s_axis_tvalid_2(tv[1]),
    .s_axis_tready_2(rdy0[1]), .s_axis_tlast_2(tl[1]),
    .s_axis_tdata_3(td[2]), .s_axis_tkeep_3(4'hF), .s_axis_tvalid_3(tv[2]),
    .s_axis_tready_3(rdy0[2]), .s_axis_tlast_3(tl[2]),
    .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tvalid(m_tvalid0),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast0)
`ifdef ENSEMBLE_VOTE_STATS_EN
    , .disagree_cnt(dis_cnt0), .tlast_err(terr0)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Most frequent class wins (first slot among equals); all distinct -> tie slot.
  function automatic logic [31:0] vote(input int a, input int b, input int c, input int tie);
    int v [3];
    int best, best_cnt, cnt;
    v = '{a, b, c};
    best = v[0];
    best_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      for (int j = 0; j < 3; j++) if (v[j] == v[i]) cnt++;
      if (cnt > best_cnt) begin
        best_cnt = cnt;
        best = v[i];
      end
    end
    if (best_cnt == 1) best = v[tie];
    return (32'(best_cnt) << 16) | 32'(best);
  endfunction

  // Compare-and-advance model, sampled on the falling edge.
  initial begin
    bit [2:0] exp_rdy, acc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_tready", 32'(rdy), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_tkeep", 32'(m_tkeep), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        m_run = 1'b0;
        have = '0;
        o_valid = 1'b0;
`ifdef ENSEMBLE_VOTE_STATS_EN
        dis_m = 0;
        terr_m = 1'b0;
`endif
      end else begin
        for (int i = 0; i < 3; i++) exp_rdy[i] = m_run && !o_valid && !have[i];
        check("tready", 32'(rdy), 32'(exp_rdy));
        check("tready_tie0", 32'(rdy0), 32'(exp_rdy));
        check("tvalid", 32'(m_tvalid), 32'(o_valid));
        check("tvalid_tie0", 32'(m_tvalid0), 32'(o_valid));
        if (o_valid) begin
          check("tdata", m_tdata, o_data2);
          check("tdata_tie0", m_tdata0, o_data0);
          check("tkeep", 32'(m_tkeep), 32'hF);
          check("tlast", 32'(m_tlast), 32'd1);
        end
`ifdef ENSEMBLE_VOTE_STATS_EN
        check("disagree_cnt", dis_cnt, 32'(dis_m));
        check("tlast_err", 32'(terr), 32'(terr_m));
`endif
        acc = exp_rdy & tv;
        if (o_valid) begin
          if (m_tready) begin
            o_valid = 1'b0;
            have = '0;
            n_out++;
            last_out = m_tdata;
            last_out0 = m_tdata0;
`ifdef ENSEMBLE_VOTE_STATS_EN
            if (o_data2[17:16] != 2'd3 && dis_m != -1) dis_m++;
`endif
          end
        end else if (&have) begin
          o_valid = 1'b1;
          o_data2 = vote(cls[0], cls[1], cls[2], 2);
          o_data0 = vote(cls[0], cls[1], cls[2], 0);
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
              have[i] = 1'b1;
              cls[i] = int'(td[i][7:0]);
            end
          end
        end
`ifdef ENSEMBLE_VOTE_STATS_EN
        if (|(acc & ~tl)) terr_m = 1'b1;
`endif
        m_run = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit [2:0] m, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] d3, input bit [2:0] lst = 3'b111);
    tv = m;
    td[0] = d1;
    td[1] = d2;
    td[2] = d3;
    tl = lst;
    tick();
    tv = '0;
    tl = 3'b111;
  endtask

  task automatic wait_out(input int n0);
    int seen;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (n_out > n0) begin
        seen = 1;
        break;
      end
      tick();
    end
    if (seen == 0) check("out_timeout", 32'(n_out - n0), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int n0;
    td[0] = '0;
    td[1] = '0;
    td[2] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Unanimous, simultaneous, junk above the class field
    n0 = n_out;
    put(3'b111, 32'hABCD_0105, 32'h0000_FF05, 32'h1234_5605);
    wait_out(n0);
    check("unanimous", last_out, 32'h0003_0005);

    // Staggered majority
    n0 = n_out;
    put(3'b100, 0, 0, 7);
    tick(); tick();
    put(3'b001, 2, 0, 0);
    tick(); tick();
    put(3'b010, 0, 2, 0);
    wait_out(n0);
    check("staggered", last_out, 32'h0002_0002);

    // Three-way tie under both tie slots
    n0 = n_out;
    put(3'b111, 1, 4, 9);
    wait_out(n0);
    check("tie_sel2", last_out, 32'h0001_0009);
    check("tie_sel0", last_out0, 32'h0001_0001);

    // Output backpressure with stream 1 pushing
    m_tready = 1'b0;
    put(3'b111, 3, 3, 8);
    tick();
    tv[0] = 1'b1;
    td[0] = 6;
    repeat (10) tick();
    n0 = n_out;
    m_tready = 1'b1;
    tick();
    check("bp_out", last_out, 32'h0002_0003);
    tick();
    tv[0] = 1'b0;
    put(3'b110, 0, 6, 6);
    wait_out(n0 + 1);
    check("bp_next", last_out, 32'h0003_0006);

    // Reset with two slots filled
    put(3'b011, 4, 4, 0);
    tick();
    do_reset();
    n0 = n_out;
    put(3'b111, 3, 3, 3);
    wait_out(n0);
    repeat (5) tick();
    check("post_reset", last_out, 32'h0003_0003);
    check("one_result", 32'(n_out - n0), 32'd1);

    // Stats sequence from a fresh reset
    do_reset();
    n0 = n_out;
    put(3'b111, 2, 2, 2);
    wait_out(n0);
    check("s_unan", last_out, 32'h0003_0002);
    put(3'b111, 1, 1, 5);
    wait_out(n0 + 1);
    check("s_maj_a", last_out, 32'h0002_0001);
    put(3'b111, 1, 2, 3);
    wait_out(n0 + 2);
    check("s_tie", last_out, 32'h0001_0003);
    put(3'b111, 4, 6, 6, 3'b101);
    wait_out(n0 + 3);
    check("s_maj_b", last_out, 32'h0002_0006);
    tick(); tick();
`ifdef ENSEMBLE_VOTE_STATS_EN
    check("stats_disagree", dis_cnt, 32'd3);
    check("stats_tlast_err", 32'(terr), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
